// File: rtl/design_file.sv
// Registered signed arithmetic unit for the calculator datapath.
// Two 5-bit two's-complement operands and a 2-bit opcode give a 9-bit
// two's-complement result one clock later, with divide-by-zero and
// multiply-overflow status flags. All outputs come straight from flops.
module design_file (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic signed [4:0] A,
  input  logic signed [4:0] B,
  input  logic        [1:0] a_s,
  output logic signed [8:0] result,
  output logic              out_valid,
  output logic              div_by_zero,
  output logic              ovf
);

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_e;

  op_e op;
  assign op = op_e'(a_s);

  // Operands widened once so every arithmetic path sees the sign.
  logic signed [8:0] a_ext;
  logic signed [8:0] b_ext;
  logic signed [9:0] a_mul;
  logic signed [9:0] b_mul;

  assign a_ext = {{4{A[4]}}, A};
  assign b_ext = {{4{B[4]}}, B};
  assign a_mul = {{5{A[4]}}, A};
  assign b_mul = {{5{B[4]}}, B};

  // Add / subtract: ranges -32..31 always fit in 9 bits.
  logic signed [8:0] sum;
  logic signed [8:0] diff;

  assign sum  = a_ext + b_ext;
  assign diff = a_ext - b_ext;

  // Multiply: the 10-bit product is exact for any 5x5 signed pair. Only
  // -16 * -16 = 256 leaves the 9-bit range, seen as bit 9 differing from bit 8.
  logic signed [9:0] prod;
  logic              mul_ovf;

  assign prod    = a_mul * b_mul;
  assign mul_ovf = prod[9] ^ prod[8];

  // Divide works on magnitudes; the sign is reapplied afterwards, which
  // gives truncation toward zero. |-16| = 16 still fits in 5 unsigned bits.
  logic       [4:0] mag_a;
  logic       [4:0] mag_b;
  logic             quo_neg;
  logic             b_zero;

  assign mag_a   = A[4] ? (~A + 5'd1) : A;
  assign mag_b   = B[4] ? (~B + 5'd1) : B;
  assign quo_neg = A[4] ^ B[4];
  assign b_zero  = (B == 5'sd0);

  logic       [5:0] rem;
  logic       [4:0] quo_mag;
  logic       [8:0] quo_ext;
  logic signed [8:0] quo;

  // Unrolled restoring division of the operand magnitudes, MSB first.
  always_comb begin
    // NOTE: blocking assignments here because each loop step must see the
    // remainder produced by the previous step within the same evaluation.
    rem     = '0;
    quo_mag = '0;
    for (int i = 4; i >= 0; i--) begin
      rem = {rem[4:0], mag_a[i]};
      if (rem >= {1'b0, mag_b}) begin
        rem        = rem - {1'b0, mag_b};
        quo_mag[i] = 1'b1;
      end
    end
    quo_ext = {4'b0000, quo_mag};
    quo     = quo_neg ? $signed(~quo_ext + 9'd1) : $signed(quo_ext);
  end

  logic signed [8:0] result_d, result_q;
  logic              dbz_d,    dbz_q;
  logic              ovf_d,    ovf_q;
  logic              out_valid_q;

  // Select the operation result and its status flags.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves a value unassigned, which would infer a latch.
    result_d = '0;
    dbz_d    = 1'b0;
    ovf_d    = 1'b0;
    unique case (op)
      OP_ADD: result_d = sum;
      OP_SUB: result_d = diff;
      OP_MUL: begin
        result_d = prod[8:0];
        ovf_d    = mul_ovf;
      end
      OP_DIV: begin
        if (b_zero) begin
          dbz_d = 1'b1;
        end else begin
          result_d = quo;
        end
      end
      default: result_d = '0;
    endcase
  end

  // Output registers: reset wins, new results load on in_valid, else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        result_q <= result_d;
        dbz_q    <= dbz_d;
        ovf_q    <= ovf_d;
      end
    end
  end

  assign result      = result_q;
  assign out_valid   = out_valid_q;
  assign div_by_zero = dbz_q;
  assign ovf         = ovf_q;

endmodule

// File: tb/tb_design_file.sv
// Scoreboard bench for design_file: the driver pushes the expected outputs
// for every cycle it issues, and a monitor on the falling edge pops and
// compares them against what the design presents.
module tb_design_file;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic signed [4:0] A;
  logic signed [4:0] B;
  logic        [1:0] a_s;
  logic signed [8:0] result;
  logic              out_valid;
  logic              div_by_zero;
  logic              ovf;

  design_file dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .A           (A),
    .B           (B),
    .a_s         (a_s),
    .result      (result),
    .out_valid   (out_valid),
    .div_by_zero (div_by_zero),
    .ovf         (ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       vld;
    logic [8:0] res;
    logic       dbz;
    logic       ovf;
  } exp_t;

  exp_t sb[$];
  exp_t held;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  // Reference model from the arithmetic rules, using plain integers.
  function automatic exp_t model(input int a, input int b, input logic [1:0] op);
    exp_t e;
    int   r;
    e = '0;
    e.vld = 1'b1;
    r = 0;
    case (op)
      2'b00: r = a + b;
      2'b01: r = a - b;
      2'b10: begin
        r = a * b;
        e.ovf = (r > 255) || (r < -256);
      end
      default: begin
        if (b == 0) begin
          r = 0;
          e.dbz = 1'b1;
        end else begin
          r = a / b;
        end
      end
    endcase
    e.res = 9'(r);
    return e;
  endfunction

  // Issue one clock of stimulus and record what must appear after the edge.
  task automatic cycle(input logic r, input logic v, input int a, input int b,
                       input logic [1:0] op);
    exp_t e;
    rst      = r;
    in_valid = v;
    A        = 5'(a);
    B        = 5'(b);
    a_s      = op;
    if (r) begin
      held = '0;
      e    = '0;
    end else if (v) begin
      held = model(a, b, op);
      e    = held;
    end else begin
      e     = held;
      e.vld = 1'b0;
    end
    held.vld = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the design's outputs with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cyc++;
      total++;
      if (out_valid !== e.vld || result !== e.res ||
          div_by_zero !== e.dbz || ovf !== e.ovf) begin
        bad++;
        $display("FAIL cycle%0d: got vld=%b res=%0d dbz=%b ovf=%b, want vld=%b res=%0d dbz=%b ovf=%b",
                 cyc, out_valid, result, div_by_zero, ovf,
                 e.vld, $signed(e.res), e.dbz, e.ovf);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int a;
    int b;
    held = '0;

    // Reset for two cycles, then idle.
    cycle(1, 0, 0, 0, 2'b00);
    cycle(1, 0, 0, 0, 2'b00);
    cycle(0, 0, 3, -2, 2'b10);
    cycle(0, 0, -9, 4, 2'b11);

    // Add and subtract back-to-back.
    cycle(0, 1,   8,  7, 2'b00);
    cycle(0, 1, -10,  5, 2'b00);
    cycle(0, 1,  10,  3, 2'b01);
    cycle(0, 1,  -8, -4, 2'b01);

    // Multiply, including the single overflow case.
    cycle(0, 1,   4,   3, 2'b10);
    cycle(0, 1,  -6,   2, 2'b10);
    cycle(0, 1, -16, -16, 2'b10);
    cycle(0, 1,  15, -16, 2'b10);

    // Divide, truncation toward zero, -16/-1 and divide by zero.
    cycle(0, 1,   8,  4, 2'b11);
    cycle(0, 1,  -8,  2, 2'b11);
    cycle(0, 1,  -7,  2, 2'b11);
    cycle(0, 1,   7, -2, 2'b11);
    cycle(0, 1, -16, -1, 2'b11);
    cycle(0, 1,   7,  0, 2'b11);
    cycle(0, 1,   1,  1, 2'b00);

    // Reset on the same edge as an operation discards it.
    cycle(1, 1, 3, 3, 2'b00);
    cycle(0, 1, 3, 3, 2'b00);

    // Hold with in_valid low while inputs wander.
    cycle(0, 1,  5,  5, 2'b00);
    cycle(0, 0, -3,  7, 2'b10);
    cycle(0, 0, 11, -9, 2'b11);
    cycle(0, 0, -16, 0, 2'b11);

    // Randomised traffic with occasional resets and idle cycles.
    for (int n = 0; n < 400; n++) begin
      a = int'($urandom_range(31)) - 16;
      b = ($urandom_range(7) == 0) ? 0 : int'($urandom_range(31)) - 16;
      cycle(($urandom_range(29) == 0), ($urandom_range(4) != 0), a, b,
            2'($urandom_range(3)));
    end

    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked entries, want 0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
